// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Character timing assumes 9600 baud from a 100 MHz clock.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } tx_arb_state_t;

    localparam int BAUD_DIV        = 10416;
    localparam int CHAR_CYC        = 10 * BAUD_DIV;
    localparam int TIMEOUT_CYC_DEF = 120000;

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin pick: searches upward from ptr+1 with wrap.
// Produces a one-hot grant and an any-request flag.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic                 any_o
);

    int idx;

    // Walk the farthest slot first so the nearest requester overwrites it.
    always_comb begin
        gnt_o = '0;
        any_o = |req_i;
        idx   = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART serializer,
// with a watchdog and a post-reset quiet period.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               iclk,
    input  logic               irst,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         uart_tx_data_o,
    output logic               uart_tx_en_o,
    input  logic               uart_tx_done_i,
    output logic               busy_o,
    output logic               timeout_err_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_EXP = TW'(TIMEOUT_CYC - 1);

    tx_arb_state_t    state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d, timer_inc;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d, pick_idx;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ready_q, ready_d, pick_gnt;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             en_q, en_d;
    logic             err_q, err_d;
    logic             pick_any;

    uart_rr_pick #(.N(N_REQ)) u_pick (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_gnt[k]) pick_idx = PW'(k);
        end
    end

    assign timer_inc = (timer_q == T_MAX) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        en_d    = 1'b0;
        ready_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (timer_q == T_MAX) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    data_d  = req_data_i[8*pick_idx +: 8];
                    last_d  = req_last_i[pick_idx];
                    en_d    = 1'b1;
                    ready_d = pick_gnt;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end
            ST_WAIT: begin
                timer_d = timer_inc;
                // Done beats a coincident watchdog expiry.
                if (uart_tx_done_i) begin
                    timer_d = '0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = gidx_q;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (timer_q == T_EXP) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    err_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                timer_d = timer_inc;
                if (req_valid_i[gidx_q]) begin
                    state_d = ST_ISSUE;
                    data_d  = req_data_i[8*gidx_q +: 8];
                    last_d  = req_last_i[gidx_q];
                    en_d    = 1'b1;
                    ready_d = grant_q;
                end else if (timer_q == T_EXP) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= ST_INIT;
            timer_q <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            gidx_q  <= '0;
            grant_q <= '0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign grant_o        = grant_q;
    assign uart_tx_data_o = data_q;
    assign uart_tx_en_o   = en_q;
    assign timeout_err_o  = err_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: requester queues and a serializer that answers
// done 150 cycles after each en, with TIMEOUT_CYC = 200.
module tb_uart_tx_arbiter;

    logic        iclk;
    logic        irst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_done;
    logic        busy;
    logic        terr;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(200)) dut (
        .iclk           (iclk),
        .irst           (irst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .grant_o        (grant),
        .uart_tx_data_o (tx_data),
        .uart_tx_en_o   (tx_en),
        .uart_tx_done_i (tx_done),
        .busy_o         (busy),
        .timeout_err_o  (terr)
    );

    logic [8:0] rq [4][$];
    int         log_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cnt = 0;
    int         ndone = 0;
    int         nerr = 0;
    bit         sup = 0;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // sel 0: en, 1: idle, 2: timeout pulse
    task automatic wait_for(input int sel, input int lim, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < lim) begin
            tick;
            n++;
            hit = (sel == 0) ? tx_en : (sel == 1) ? !busy : terr;
        end
    endtask

    task automatic wait_log(input int sz);
        int n;
        n = 0;
        while ((log_q.size() < sz || busy) && n < 2000) begin
            tick;
            n++;
        end
    endtask

    // Requester queues and serializer model, updated on the falling edge
    initial begin
        int who;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        forever begin
            @(negedge iclk);
            for (int k = 0; k < 4; k++) begin
                if (req_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                req_valid[k]        = rq[k].size() > 0;
                req_data[8*k +: 8]  = req_valid[k] ? rq[k][0][7:0] : 8'h00;
                req_last[k]         = req_valid[k] ? rq[k][0][8] : 1'b0;
            end
            tx_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    ndone++;
                end
            end
            if (terr) nerr++;
            if (tx_en) begin
                who = 0;
                for (int k = 0; k < 4; k++) if (grant[k]) who = k;
                log_q.push_back(who * 256 + int'(tx_data));
                if (sup) sup = 0;
                else cnt = 150;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, base, bad, nd0, en_seen;
        irst = 1'b1;
        rq[0].push_back({1'b1, 8'hA5});
        tick;
        tick;
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_en", tx_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err", terr, 0);
        irst = 1'b0;

        wait_for(0, 400, n);
        chk("init_en_lat", n, 202);
        chk("first_data", tx_data, 8'hA5);
        chk("first_ready", req_ready, 4'b0001);
        chk("first_grant", grant, 4'b0001);
        wait_for(1, 400, n);
        chk("idle_lat", n, 151);

        base = log_q.size();
        rq[1].push_back({1'b1, 8'h31});
        rq[3].push_back({1'b1, 8'h33});
        wait_log(base + 2);
        chk("rr_first", log_q[base], 32'h131);
        chk("rr_second", log_q[base + 1], 32'h333);
        base = log_q.size();
        rq[1].push_back({1'b1, 8'h41});
        rq[3].push_back({1'b1, 8'h43});
        wait_log(base + 2);
        chk("wrap_first", log_q[base], 32'h141);
        chk("wrap_second", log_q[base + 1], 32'h343);

        base = log_q.size();
        rq[2].push_back({1'b0, 8'h11});
        rq[2].push_back({1'b0, 8'h22});
        rq[2].push_back({1'b1, 8'h33});
        wait_for(0, 50, n);
        chk("lock_grant0", grant, 4'b0100);
        rq[0].push_back({1'b1, 8'hC0});
        bad = 0;
        n = 0;
        while (busy && n < 2000) begin
            if (grant !== 4'b0100) bad++;
            tick;
            n++;
        end
        chk("lock_grant", bad, 0);
        wait_log(base + 4);
        chk("pkt_b0", log_q[base], 32'h211);
        chk("pkt_b1", log_q[base + 1], 32'h222);
        chk("pkt_b2", log_q[base + 2], 32'h233);
        chk("pkt_after", log_q[base + 3], 32'h0C0);

        sup = 1;
        base = log_q.size();
        rq[1].push_back({1'b1, 8'h55});
        rq[2].push_back({1'b1, 8'h66});
        wait_for(0, 50, n);
        chk("wd_grant", grant, 4'b0010);
        wait_for(2, 400, n);
        chk("wd_lat", n, 201);
        chk("wd_release", grant, 0);
        tick;
        chk("wd_pulse_once", terr, 0);
        wait_log(base + 2);
        chk("wd_next", log_q[base + 1], 32'h266);
        chk("wd_count", nerr, 1);

        base = log_q.size();
        rq[3].push_back({1'b0, 8'h71});
        wait_for(0, 50, n);
        wait_for(2, 500, n);
        chk("hold_lat", n, 351);
        chk("hold_release", grant, 0);
        repeat (50) tick;
        rq[3].push_back({1'b1, 8'h72});
        wait_log(base + 2);
        chk("hold_next", log_q[base + 1], 32'h372);

        rq[0].push_back({1'b1, 8'h99});
        wait_for(0, 50, n);
        repeat (20) tick;
        #2;
        irst = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_en", tx_en, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_busy", busy, 1);
        tick;
        tick;
        irst = 1'b0;
        nd0 = ndone;
        en_seen = 0;
        n = 0;
        while (busy && n < 400) begin
            tick;
            n++;
            if (tx_en) en_seen++;
        end
        chk("reinit_len", n, 201);
        chk("reinit_no_en", en_seen, 0);
        chk("done_in_init", ndone - nd0, 1);
        chk("err_total", nerr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
